credential_loader: RTL and testbench

- Initiator side of the access-control load interface.
- Collects a user ID and then a password from the 16 toggle switches, one word per shaped enter-button press.
- Presents each word to the access-control responder with a single-cycle load strobe, then waits a bounded window for the grant feedback.
- Reports grant or deny to process control, counts failed attempts and locks out after too many.

---
 rtl/credential_loader_pkg.sv | 23 ++
 rtl/credential_loader_grant_timeout_timer.sv | 30 +++
 rtl/credential_loader.sv | 144 ++++++++++++++
 tb/tb_credential_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/credential_loader_pkg.sv
// Shared types and widths for the credential loader.
package credential_loader_pkg;

  // Word widths: switches are 16 bits, the access-control word is 18 bits.
  localparam int DATA_W = 18;
  localparam int SW_W   = 16;
  localparam int PAD_W  = DATA_W - SW_W;

  // Width of the consecutive-denial counter.
  localparam int CNT_W  = 3;

  // FSM state encoding (also visible on the debug state output).
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_ID    = 3'd1;
  localparam state_t ST_LOAD_ID    = 3'd2;
  localparam state_t ST_WAIT_PW    = 3'd3;
  localparam state_t ST_LOAD_PW    = 3'd4;
  localparam state_t ST_WAIT_GRANT = 3'd5;
  localparam state_t ST_REPORT     = 3'd6;
  localparam state_t ST_LOCKED     = 3'd7;

endpackage

// File: rtl/credential_loader_grant_timeout_timer.sv
// Counts cycles spent waiting for grant feedback; flags the last cycle of the window.
module grant_timeout_timer #(
  parameter int GRANT_WAIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = $clog2(GRANT_WAIT);
  localparam logic [TW-1:0] LAST = TW'(GRANT_WAIT - 1);

  logic [TW-1:0] r_count;

  // Clear has priority so the count always starts at zero on entry to the wait window.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/credential_loader.sv
// Initiator side of the access-control load interface: collects user ID and
// password words, strobes them to the responder, waits for grant and tracks lockout.
//
// Handshake: i_enter_btn is a single-cycle shaped pulse, captured only in WAIT_ID or
// WAIT_PW; o_data_load is a single-cycle strobe with o_data_out stable in that cycle
// and held until the next capture; there is no back-pressure from the responder.
module credential_loader
  import credential_loader_pkg::*;
#(
  parameter int GRANT_WAIT   = 16,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cancel,
  input  logic              i_enter_btn,
  input  logic [SW_W-1:0]   i_switches,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_load,
  input  logic              i_access_grant,
  output logic              o_busy,
  output logic              o_result_valid,
  output logic              o_result_granted,
  output logic [CNT_W-1:0]  o_attempt_count,
  output logic              o_locked,
  output logic [2:0]        o_dbg_state
);

  localparam logic [PAD_W-1:0] DATA_PAD = '0;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ATTEMPTS);

  state_t             r_state;
  state_t             w_next;
  logic               w_capture;
  logic               w_decide;
  logic               w_expired;
  logic [SW_W-1:0]    r_word;
  logic               r_granted;
  logic [CNT_W-1:0]   r_attempts;
  logic [CNT_W-1:0]   w_attempts_inc;

  // Saturating increment of the denial counter.
  assign w_attempts_inc = (r_attempts == MAX_CNT) ? r_attempts : r_attempts + 1'b1;

  grant_timeout_timer #(
    .GRANT_WAIT (GRANT_WAIT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (r_state == ST_LOAD_PW),
    .i_enable  (r_state == ST_WAIT_GRANT),
    .o_expired (w_expired)
  );

  // Next-state logic; cancel beats enter and grant in every cancellable state.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_decide  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        if (i_cancel) begin
          w_next = ST_IDLE;
        end else if (i_enter_btn) begin
          w_next    = ST_LOAD_ID;
          w_capture = 1'b1;
        end
      end
      ST_LOAD_ID: begin
        w_next = i_cancel ? ST_IDLE : ST_WAIT_PW;
      end
      ST_WAIT_PW: begin
        if (i_cancel) begin
          w_next = ST_IDLE;
        end else if (i_enter_btn) begin
          w_next    = ST_LOAD_PW;
          w_capture = 1'b1;
        end
      end
      ST_LOAD_PW: begin
        w_next = i_cancel ? ST_IDLE : ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (i_cancel) begin
          w_next = ST_IDLE;
        end else if (i_access_grant || w_expired) begin
          w_next   = ST_REPORT;
          w_decide = 1'b1;
        end
      end
      ST_REPORT: begin
        if (!r_granted && (w_attempts_inc == MAX_CNT)) w_next = ST_LOCKED;
        else                                           w_next = ST_IDLE;
      end
      ST_LOCKED: begin
        w_next = ST_LOCKED;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Captured switch word, held until the next capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         r_word <= '0;
    else if (w_capture) r_word <= i_switches;
  end

  // Outcome register: latched when leaving WAIT_GRANT, held until the next result.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        r_granted <= 1'b0;
    else if (w_decide) r_granted <= i_access_grant;
  end

  // Consecutive-denial counter, updated in the REPORT cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_attempts <= '0;
    end else if (r_state == ST_REPORT) begin
      r_attempts <= r_granted ? '0 : w_attempts_inc;
    end
  end

  assign o_data_out       = {DATA_PAD, r_word};
  assign o_data_load      = (r_state == ST_LOAD_ID) || (r_state == ST_LOAD_PW);
  assign o_busy           = (r_state != ST_IDLE) && (r_state != ST_LOCKED);
  assign o_result_valid   = (r_state == ST_REPORT);
  assign o_result_granted = r_granted;
  assign o_attempt_count  = r_attempts;
  assign o_locked         = (r_state == ST_LOCKED);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_credential_loader.sv
// Directed bench for credential_loader with hand-computed expectations.
module tb_credential_loader;

  localparam int GW = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cancel;
  logic        enter_btn;
  logic [15:0] switches;
  logic [17:0] data_out;
  logic        data_load;
  logic        access_grant;
  logic        busy;
  logic        result_valid;
  logic        result_granted;
  logic [2:0]  attempt_count;
  logic        locked;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  credential_loader #(
    .GRANT_WAIT   (GW),
    .MAX_ATTEMPTS (3)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_cancel         (cancel),
    .i_enter_btn      (enter_btn),
    .i_switches       (switches),
    .o_data_out       (data_out),
    .o_data_load      (data_load),
    .i_access_grant   (access_grant),
    .o_busy           (busy),
    .o_result_valid   (result_valid),
    .o_result_granted (result_granted),
    .o_attempt_count  (attempt_count),
    .o_locked         (locked),
    .o_dbg_state      (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Press enter with a switch word; returns in the load cycle and checks the strobe.
  task automatic press(input string tag, input logic [15:0] sw);
    switches  = sw;
    enter_btn = 1'b1;
    tick();
    enter_btn = 1'b0;
    chk({tag, "_load"}, {31'd0, data_load}, 32'd1);
    chk({tag, "_data"}, {14'd0, data_out}, {16'd0, sw});
  endtask

  // Wait (bounded) for result_valid; lat is cycles since the current cycle.
  task automatic wait_result(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Start, enter ID and password; returns in the password load cycle.
  task automatic login(input string tag, input logic [15:0] id, input logic [15:0] pw);
    pulse_start();
    press({tag, "_id"}, id);
    tick();
    press({tag, "_pw"}, pw);
  endtask

  int lat;
  bit seen;
  bit any_valid;
  bit any_load;

  initial begin
    rst = 1'b0; start = 1'b0; cancel = 1'b0; enter_btn = 1'b0;
    switches = 16'h0; access_grant = 1'b0;
    #2;
    // Reset values
    chk("rst_data_out", {14'd0, data_out}, 32'd0);
    chk("rst_load", {31'd0, data_load}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_granted", {31'd0, result_granted}, 32'd0);
    chk("rst_count", {29'd0, attempt_count}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    do_reset();

    // enter/cancel in IDLE are ignored
    enter_btn = 1'b1; cancel = 1'b1; switches = 16'hAAAA;
    tick();
    enter_btn = 1'b0; cancel = 1'b0;
    chk("idle_ignore_state", {29'd0, dbg_state}, 32'd0);
    chk("idle_ignore_data", {14'd0, data_out}, 32'd0);

    // Login 1: grant raised 3 cycles after password load
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_state_wait_id", {29'd0, dbg_state}, 32'd1);
    press("t1_id", 16'h1234);
    chk("t1_id_data18", {14'd0, data_out}, 32'h01234);
    tick();
    chk("t1_wait_pw_noload", {31'd0, data_load}, 32'd0);
    chk("t1_wait_pw_hold", {14'd0, data_out}, 32'h01234);
    press("t1_pw", 16'hBEEF);
    chk("t1_pw_data18", {14'd0, data_out}, 32'h0BEEF);
    tick(); tick(); tick();
    access_grant = 1'b1;
    tick();
    chk("t1_valid", {31'd0, result_valid}, 32'd1);
    chk("t1_granted", {31'd0, result_granted}, 32'd1);
    access_grant = 1'b0;
    tick();
    chk("t1_valid_pulse", {31'd0, result_valid}, 32'd0);
    chk("t1_granted_hold", {31'd0, result_granted}, 32'd1);
    chk("t1_count", {29'd0, attempt_count}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Login 2: grant held low -> timeout denial
    login("t2", 16'h0001, 16'h0002);
    wait_result(lat, seen);
    chk("t2_seen", {31'd0, seen}, 32'd1);
    chk("t2_latency", lat, GW + 1);
    chk("t2_granted", {31'd0, result_granted}, 32'd0);
    tick();
    chk("t2_count", {29'd0, attempt_count}, 32'd1);
    chk("t2_idle", {29'd0, dbg_state}, 32'd0);

    // Cancel together with enter in WAIT_PW
    pulse_start();
    press("t4_id", 16'h4444);
    tick();
    switches = 16'h5555; enter_btn = 1'b1; cancel = 1'b1;
    tick();
    enter_btn = 1'b0; cancel = 1'b0;
    chk("t4_noload", {31'd0, data_load}, 32'd0);
    chk("t4_idle", {29'd0, dbg_state}, 32'd0);
    chk("t4_data_hold", {14'd0, data_out}, 32'h04444);
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid) any_valid = 1'b1;
    end
    chk("t4_no_result", {31'd0, any_valid}, 32'd0);
    chk("t4_count", {29'd0, attempt_count}, 32'd1);

    // Grant high only during LOAD_PW is not sampled
    login("t5", 16'h0005, 16'h0006);
    access_grant = 1'b1;
    tick();
    access_grant = 1'b0;
    wait_result(lat, seen);
    chk("t5_seen", {31'd0, seen}, 32'd1);
    chk("t5_latency", lat + 1, GW + 1);
    chk("t5_granted", {31'd0, result_granted}, 32'd0);
    tick();
    chk("t5_count", {29'd0, attempt_count}, 32'd2);

    // Three consecutive denials from a clean reset -> lockout
    do_reset();
    for (int k = 0; k < 3; k++) begin
      login("t3", 16'h0030, 16'h0031);
      wait_result(lat, seen);
      chk("t3_seen", {31'd0, seen}, 32'd1);
      tick();
    end
    chk("t3_locked", {31'd0, locked}, 32'd1);
    chk("t3_count", {29'd0, attempt_count}, 32'd3);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    any_load = 1'b0;
    switches = 16'h7777; enter_btn = 1'b1;
    tick();
    enter_btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (data_load) any_load = 1'b1;
      tick();
    end
    chk("t3_locked_noload", {31'd0, any_load}, 32'd0);
    chk("t3_still_locked", {29'd0, dbg_state}, 32'd7);
    rst = 1'b0;
    #1;
    chk("t3_rst_locked", {31'd0, locked}, 32'd0);
    chk("t3_rst_count", {29'd0, attempt_count}, 32'd0);
    tick();
    rst = 1'b1;

    // Reset asserted in the LOAD_ID cycle
    pulse_start();
    press("t6_id", 16'h6666);
    rst = 1'b0;
    #1;
    chk("t6_load_drop", {31'd0, data_load}, 32'd0);
    chk("t6_data", {14'd0, data_out}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_state", {29'd0, dbg_state}, 32'd0);
    tick();
    rst = 1'b1;
    login("t6b", 16'h0061, 16'h0062);
    access_grant = 1'b1;
    wait_result(lat, seen);
    chk("t6b_seen", {31'd0, seen}, 32'd1);
    chk("t6b_latency", lat, 32'd2);
    chk("t6b_granted", {31'd0, result_granted}, 32'd1);
    access_grant = 1'b0;
    tick();
    chk("t6b_count", {29'd0, attempt_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
